// File: rtl/pm1_sched_pkg.sv
// ============================================================================
// pm1_sched_pkg : shared widths, state encoding and bit maps for the scheduler
// Revision: 1.0
// ============================================================================
`default_nettype none

package pm1_sched_pkg;

  localparam int unsigned IN_W  = 16;
  localparam int unsigned OUT_W = 13;

  localparam logic [OUT_W-1:0] MISR_POLY_DEFAULT = 13'h1C80;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_e;

  // pm1 input pin positions within a 16-bit vector
  localparam int unsigned A_BIT = 15;
  localparam int unsigned B_BIT = 14;
  localparam int unsigned C_BIT = 13;
  localparam int unsigned D_BIT = 12;
  localparam int unsigned E_BIT = 11;
  localparam int unsigned G_BIT = 10;
  localparam int unsigned H_BIT = 9;
  localparam int unsigned I_BIT = 8;
  localparam int unsigned J_BIT = 7;
  localparam int unsigned K_BIT = 6;
  localparam int unsigned L_BIT = 5;
  localparam int unsigned M_BIT = 4;
  localparam int unsigned N_BIT = 3;
  localparam int unsigned O_BIT = 2;
  localparam int unsigned P_BIT = 1;
  localparam int unsigned Q_BIT = 0;

  // pm1 output pin positions within a 13-bit result
  localparam int unsigned R_BIT  = 12;
  localparam int unsigned S_BIT  = 11;
  localparam int unsigned T_BIT  = 10;
  localparam int unsigned U_BIT  = 9;
  localparam int unsigned V_BIT  = 8;
  localparam int unsigned W_BIT  = 7;
  localparam int unsigned X_BIT  = 6;
  localparam int unsigned Y_BIT  = 5;
  localparam int unsigned Z_BIT  = 4;
  localparam int unsigned A0_BIT = 3;
  localparam int unsigned B0_BIT = 2;
  localparam int unsigned C0_BIT = 1;
  localparam int unsigned D0_BIT = 0;

  function automatic logic [OUT_W-1:0] misr_step(
    input logic [OUT_W-1:0] sig,
    input logic [OUT_W-1:0] poly,
    input logic [OUT_W-1:0] data
  );
    logic [OUT_W-1:0] fb;
    fb = sig[OUT_W-1] ? poly : '0;
    return ({sig[OUT_W-2:0], 1'b0} ^ fb) ^ data;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pm1_sched_misr.sv
// ============================================================================
// pm1_sched_misr : 13-bit response-compaction MISR with clear priority
// Revision: 1.0
// ============================================================================
`default_nettype none

module pm1_sched_misr
  import pm1_sched_pkg::*;
#(
  parameter logic [OUT_W-1:0] POLY = MISR_POLY_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [OUT_W-1:0] din,
  output logic [OUT_W-1:0] sig
);

  logic [OUT_W-1:0] sig_q;
  logic [OUT_W-1:0] sig_d;

  // A clear on the same edge as a fold discards that fold entirely
  always_comb begin
    sig_d = sig_q;
    if (clr) begin
      sig_d = '0;
    end else if (en) begin
      sig_d = misr_step(sig_q, POLY, din);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

`default_nettype wire

// File: rtl/pm1_vector_scheduler.sv
// ============================================================================
// pm1_vector_scheduler : round-robin sharing of one pm1 datapath by two
// requesters, with settle timing, response hold and MISR compaction
// Revision: 1.0
// ============================================================================
`default_nettype none

module pm1_vector_scheduler
  import pm1_sched_pkg::*;
#(
  parameter int unsigned      SETTLE    = 1,
  parameter logic [OUT_W-1:0] MISR_POLY = MISR_POLY_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  input  logic [IN_W-1:0]  req_vec0,
  input  logic [IN_W-1:0]  req_vec1,
  output logic [1:0]       req_ready,
  output logic [IN_W-1:0]  dp_in,
  input  logic [OUT_W-1:0] dp_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [IN_W-1:0]  rsp_vec,
  output logic [OUT_W-1:0] rsp_data,
  output logic [OUT_W-1:0] sig,
  input  logic             sig_clr,
  output logic             busy,
  output logic [15:0]      count
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_e           state_q,    state_d;
  logic [3:0]       cnt_q,      cnt_d;
  logic             last_q,     last_d;
  logic [IN_W-1:0]  dp_in_q,    dp_in_d;
  logic [IN_W-1:0]  rsp_vec_q,  rsp_vec_d;
  logic             rsp_id_q,   rsp_id_d;
  logic [OUT_W-1:0] rsp_data_q, rsp_data_d;
  logic [15:0]      count_q,    count_d;

  logic             grant_id;
  logic [IN_W-1:0]  grant_vec;
  logic             misr_en;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    dp_in_d    = dp_in_q;
    rsp_vec_d  = rsp_vec_q;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
    count_d    = count_q;
    req_ready  = 2'b00;
    grant_id   = 1'b0;
    grant_vec  = req_vec0;
    misr_en    = 1'b0;

    unique case (state_q)
      IDLE: begin
        // On contention the requester that did not win last time goes first
        case (req_valid)
          2'b01:   req_ready = 2'b01;
          2'b10:   req_ready = 2'b10;
          2'b11:   req_ready = last_q ? 2'b01 : 2'b10;
          default: req_ready = 2'b00;
        endcase
        grant_id  = req_ready[1];
        grant_vec = grant_id ? req_vec1 : req_vec0;
        if (req_ready != 2'b00) begin
          dp_in_d   = grant_vec;
          rsp_vec_d = grant_vec;
          rsp_id_d  = grant_id;
          last_d    = grant_id;
          cnt_d     = 4'd0;
          state_d   = EVAL;
        end
      end
      EVAL: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == SETTLE_LAST) begin
          rsp_data_d = dp_out;
          state_d    = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          misr_en = 1'b1;
          count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      last_q     <= 1'b1;
      dp_in_q    <= '0;
      rsp_vec_q  <= '0;
      rsp_id_q   <= 1'b0;
      rsp_data_q <= '0;
      count_q    <= 16'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      dp_in_q    <= dp_in_d;
      rsp_vec_q  <= rsp_vec_d;
      rsp_id_q   <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
      count_q    <= count_d;
    end
  end

  pm1_sched_misr #(
    .POLY (MISR_POLY)
  ) u_misr (
    .clk (clk),
    .rst (rst),
    .clr (sig_clr),
    .en  (misr_en),
    .din (rsp_data_q),
    .sig (sig)
  );

  assign dp_in     = dp_in_q;
  assign rsp_vec   = rsp_vec_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign count     = count_q;
  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);

endmodule

`default_nettype wire
